// File: rtl/m_pkg.sv
// Shared M-extension types: divide operation codes, divider FSM states and
// the iteration-counter width helper.
package m_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  function automatic int div_iter_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per CALC
// cycle, sign fix-up in FIX, RISC-V divide-by-zero and overflow results preloaded.
module seq_divider
  import m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = div_iter_w(WIDTH);

  div_state_e       state_r;
  div_op_e          op_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             valid_r;

  logic             signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [WIDTH-1:0] special_res_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] fix_res_s;

  // Operand conditioning, special-case detection, one iteration step and sign fix-up.
  always_comb begin
    signed_s      = ~op[0];
    a_neg_s       = signed_s & dividend[WIDTH-1];
    b_neg_s       = signed_s & divisor[WIDTH-1];
    a_abs_s       = a_neg_s ? (-dividend) : dividend;
    b_abs_s       = b_neg_s ? (-divisor) : divisor;
    div_zero_s    = (divisor == {WIDTH{1'b0}});
    overflow_s    = signed_s
                    && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    && (divisor == {WIDTH{1'b1}});
    special_res_s = {WIDTH{1'b0}};
    if (div_zero_s) begin
      special_res_s = op[1] ? dividend : {WIDTH{1'b1}};
    end else if (overflow_s) begin
      special_res_s = op[1] ? {WIDTH{1'b0}} : dividend;
    end else begin
      special_res_s = {WIDTH{1'b0}};
    end

    // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
    trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      rem_nx_s = trial_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end

    quo_fix_s = neg_q_r ? (-quo_r) : quo_r;
    rem_fix_s = neg_r_r ? (-rem_r) : rem_r;
    if ((op_r == REM) || (op_r == REMU)) begin
      fix_res_s = rem_fix_s;
    end else begin
      fix_res_s = quo_fix_s;
    end
  end

  // Divider FSM with registered busy/valid/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= DIV;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            op_r    <= div_op_e'(op);
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= a_abs_s;
            dvs_r   <= b_abs_s;
            cnt_r   <= CNT_W'(WIDTH - 1);
            if (div_zero_s || overflow_s) begin
              state_r  <= DONE;
              result_r <= special_res_s;
              busy_r   <= 1'b0;
              valid_r  <= 1'b1;
            end else begin
              state_r <= CALC;
              busy_r  <= 1'b1;
              valid_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end
        end
        CALC: begin
          rem_r  <= rem_nx_s;
          quo_r  <= quo_nx_s;
          cnt_r  <= cnt_r - CNT_W'(1);
          busy_r <= 1'b1;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          result_r <= fix_res_s;
          state_r  <= DONE;
          busy_r   <= 1'b0;
          valid_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (WIDTH=32): results, latency,
// busy/valid shape, flush, asynchronous reset and back-to-back accept.
module tb_seq_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int NORM = 34;
  localparam int SPEC = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the valid cycle.
  // Waits for valid counting cycles after the accept edge.
  task automatic wait_done(input string nm, input int lat, input logic [31:0] exp);
    int n;
    int busy_err;
    n = 1;
    busy_err = 0;
    while (!valid && n < 60) begin
      if (busy !== 1'b1) busy_err++;
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " result"}, result, exp);
    check({nm, " busy_shape"}, {31'd0, busy}, 32'd0);
    check({nm, " busy_cycles"}, 32'(busy_err), 32'd0);
    @(negedge clk);
    check({nm, " valid_pulse"}, {31'd0, valid}, 32'd0);
    check({nm, " result_hold"}, result, exp);
  endtask

  task automatic run_op(input vec_t v);
    start    = 1'b1;
    op       = v.op;
    dividend = v.a;
    divisor  = v.b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(v.name, v.lat, v.exp);
  endtask

  initial begin
    logic [31:0] prev;
    vec_t v;
    n_cmp = 0;
    n_bad = 0;
    start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0; flush = 1'b0;
    rst_n = 1'b0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         NORM, "divu_100_7"});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          NORM, "remu_100_7"});
    vecs.push_back('{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   NORM, "div_m7_2"});
    vecs.push_back('{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   NORM, "rem_m7_2"});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          NORM, "rem_7_m2"});
    vecs.push_back('{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   NORM, "div_100_m7"});
    vecs.push_back('{OP_DIV,  32'hFFFFFFF8,   32'hFFFFFFFE,   32'd4,          NORM, "div_m8_m2"});
    vecs.push_back('{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   SPEC, "div_ovf"});
    vecs.push_back('{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          SPEC, "rem_ovf"});
    vecs.push_back('{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          NORM, "divu_big"});
    vecs.push_back('{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   NORM, "remu_big"});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   SPEC, "divu_5_0"});
    vecs.push_back('{OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   SPEC, "div_5_0"});
    vecs.push_back('{OP_REM,  32'd5,          32'd0,          32'd5,          SPEC, "rem_5_0"});
    vecs.push_back('{OP_DIVU, 32'd0,          32'd3,          32'd0,          NORM, "divu_0_3"});
    vecs.push_back('{OP_REMU, 32'd0,          32'd3,          32'd0,          NORM, "remu_0_3"});
    vecs.push_back('{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   NORM, "divu_max_1"});

    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i]);
    end
    prev = vecs[vecs.size()-1].exp;

    // Flush at cycle k+10 of a DIVU, then a fresh start the next cycle.
    start = 1'b1; op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush valid", {31'd0, valid}, 32'd0);
    check("flush result", result, prev);
    v = '{OP_DIVU, 32'd77, 32'd7, 32'd11, NORM, "after_flush"};
    run_op(v);

    // Asynchronous reset mid-CALC.
    start = 1'b1; op = OP_DIVU; dividend = 32'd500; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst valid", {31'd0, valid}, 32'd0);
    check("arst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{OP_DIVU, 32'd9, 32'd3, 32'd3, NORM, "after_reset"};
    run_op(v);

    // Back-to-back: start held through the first op, new operands in DONE.
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    begin
      int n;
      n = 1;
      @(negedge clk);
      while (!valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("b2b first latency", 32'(n), 32'(NORM));
      check("b2b first result", result, 32'd14);
      dividend = 32'd200;
      divisor  = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b busy reassert", {31'd0, busy}, 32'd1);
      check("b2b no valid", {31'd0, valid}, 32'd0);
      wait_done("b2b second", NORM, 32'd28);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
